// File: rtl/sdram_arbiter_pkg.sv
// Shared encodings for the SDRAM arbiter: command words, FSM states and bus widths.
package sdram_arbiter_pkg;

    // Bus widths of the SDRAM pin interface
    localparam int CMD_W  = 4;
    localparam int BA_W   = 2;
    localparam int ADDR_W = 13;
    localparam int DQ_W   = 16;

    // SDRAM commands as {CS#,RAS#,CAS#,WE#}
    localparam logic [CMD_W-1:0] SDR_NOP = 4'b0111;
    localparam logic [CMD_W-1:0] SDR_PRE = 4'b0010;
    localparam logic [CMD_W-1:0] SDR_AR  = 4'b0001;
    localparam logic [CMD_W-1:0] SDR_ACT = 4'b0011;
    localparam logic [CMD_W-1:0] SDR_WR  = 4'b0100;
    localparam logic [CMD_W-1:0] SDR_RD  = 4'b0101;

    // Idle bank/address driven whenever no requester owns the bus
    localparam logic [BA_W-1:0]   BA_IDLE   = 2'b11;
    localparam logic [ADDR_W-1:0] ADDR_IDLE = 13'h1fff;

    // Arbiter FSM states
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    // Which of write/read was granted most recently
    localparam logic LG_WRITE = 1'b0;
    localparam logic LG_READ  = 1'b1;

endpackage

// File: rtl/sdram_arbiter_grant.sv
// Next-grant selection taken from ARBIT: refresh first, then write/read
// with optional round-robin when both are pending.
module sdram_arbiter_grant
    import sdram_arbiter_pkg::*;
#(
    parameter bit RR_WR_RD = 1'b1
) (
    input  logic       ar_req_i,
    input  logic       wr_req_i,
    input  logic       rd_req_i,
    input  logic       last_grant_i,
    output logic [2:0] next_state_o
);

    // Priority pick; stays in ARBIT when nothing is requesting
    always_comb begin
        next_state_o = ST_ARBIT;
        if (ar_req_i) begin
            next_state_o = ST_AREF;
        end else if (wr_req_i && rd_req_i) begin
            if (RR_WR_RD && (last_grant_i == LG_WRITE)) begin
                next_state_o = ST_READ;
            end else begin
                next_state_o = ST_WRITE;
            end
        end else if (wr_req_i) begin
            next_state_o = ST_WRITE;
        end else if (rd_req_i) begin
            next_state_o = ST_READ;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: hands the pins to init, then one of refresh/write/read
// at a time, with a per-grant watchdog that forces the bus back to ARBIT.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter bit          RR_WR_RD    = 1'b1,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1000,
    parameter logic [3:0]  CMD_NOP     = 4'b0111
) (
    input  logic                ar_clk,
    input  logic                ar_rst_n,
    input  logic                init_end,
    input  logic [CMD_W-1:0]    init_cmd,
    input  logic [BA_W-1:0]     init_bank,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic                ar_req,
    input  logic                ar_end,
    input  logic [CMD_W-1:0]    ar_cmd,
    input  logic [BA_W-1:0]     ar_bank,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic                wr_req,
    input  logic                wr_end,
    input  logic [CMD_W-1:0]    wr_cmd,
    input  logic [BA_W-1:0]     wr_bank,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                wr_dq_oe,
    input  logic [DQ_W-1:0]     wr_data,
    input  logic                rd_req,
    input  logic                rd_end,
    input  logic [CMD_W-1:0]    rd_cmd,
    input  logic [BA_W-1:0]     rd_bank,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                ar_en,
    output logic                wr_en,
    output logic                rd_en,
    output logic                sdram_cke,
    output logic                sdram_cs_n,
    output logic                sdram_ras_n,
    output logic                sdram_cas_n,
    output logic                sdram_we_n,
    output logic [BA_W-1:0]     sdram_ba,
    output logic [ADDR_W-1:0]   sdram_addr,
    output logic [DQ_W-1:0]     sdram_dq_out,
    output logic                sdram_dq_oe,
    output logic                err_timeout
);

    logic [2:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             cke_q;
    logic [2:0]       arb_next;
    logic             in_grant;
    logic             grant_end;
    logic             timeout;
    logic [CMD_W-1:0] cmd;

    sdram_arbiter_grant #(
        .RR_WR_RD (RR_WR_RD)
    ) u_grant (
        .ar_req_i     (ar_req),
        .wr_req_i     (wr_req),
        .rd_req_i     (rd_req),
        .last_grant_i (last_grant_q),
        .next_state_o (arb_next)
    );

    // Decode the owner's done pulse and the watchdog expiry; ends seen in
    // the wrong state are masked out here
    always_comb begin
        in_grant  = (state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ);
        grant_end = ((state_q == ST_AREF)  && ar_end) ||
                    ((state_q == ST_WRITE) && wr_end) ||
                    ((state_q == ST_READ)  && rd_end);
        timeout   = in_grant && (cnt_q == TIMEOUT_CYC - 16'd1) && !grant_end;
    end

    // Next-state, last-grant, grant counter and sticky error
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = 16'd0;
                if (init_end) state_d = ST_ARBIT;
            end
            ST_ARBIT: begin
                cnt_d   = 16'd0;
                state_d = arb_next;
                if (arb_next == ST_WRITE) last_grant_d = LG_WRITE;
                else if (arb_next == ST_READ) last_grant_d = LG_READ;
            end
            ST_AREF, ST_WRITE, ST_READ: begin
                if (grant_end || timeout) begin
                    state_d = ST_ARBIT;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (timeout) err_d = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Control registers; async active-low reset
    always_ff @(posedge ar_clk or negedge ar_rst_n) begin
        if (!ar_rst_n) begin
            state_q      <= ST_INIT;
            last_grant_q <= LG_READ;
            cnt_q        <= 16'd0;
            err_q        <= 1'b0;
            cke_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            cke_q        <= 1'b1;
        end
    end

    // Pin mux; the bus idles at NOP until the first clock after reset so the
    // pins show reset values while ar_rst_n is low
    always_comb begin
        cmd          = CMD_NOP;
        sdram_ba     = BA_IDLE;
        sdram_addr   = ADDR_IDLE;
        sdram_dq_out = '0;
        sdram_dq_oe  = 1'b0;
        if (cke_q && !timeout) begin
            case (state_q)
                ST_INIT: begin
                    cmd        = init_cmd;
                    sdram_ba   = init_bank;
                    sdram_addr = init_addr;
                end
                ST_AREF: begin
                    cmd        = ar_cmd;
                    sdram_ba   = ar_bank;
                    sdram_addr = ar_addr;
                end
                ST_WRITE: begin
                    cmd          = wr_cmd;
                    sdram_ba     = wr_bank;
                    sdram_addr   = wr_addr;
                    sdram_dq_out = wr_data;
                    sdram_dq_oe  = wr_dq_oe;
                end
                ST_READ: begin
                    cmd        = rd_cmd;
                    sdram_ba   = rd_bank;
                    sdram_addr = rd_addr;
                end
                default: ;
            endcase
        end
    end

    // Grants drop in the same cycle as the done pulse so an owner cannot restart
    always_comb begin
        ar_en = (state_q == ST_AREF)  && !ar_end;
        wr_en = (state_q == ST_WRITE) && !wr_end;
        rd_en = (state_q == ST_READ)  && !rd_end;
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke   = cke_q;
    assign err_timeout = err_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Central arbiter/scheduler of the SDRAM controller; sits between the init, auto-refresh, write and read sub-controllers and the SDRAM command/address/data pins.
- Holds the bus for the init sequencer until init_end, then grants one requester at a time.
- Fixed priority: refresh > (write/read, optionally round-robin).
- Muxes the granted requester's {CS#,RAS#,CAS#,WE#}, bank, address and write data onto the SDRAM bus.

Parameters:
RR_WR_RD, 1, 1 = alternate write/read when both pend; 0 = write always beats read
TIMEOUT_CYC, 16'd1000, maximum cycles a grant may stay in AREF/WRITE/READ before forced release
CMD_NOP, 4'b0111, idle command {CS#,RAS#,CAS#,WE#}

Ports:
ar_clk  in  1  clock (100 MHz)
ar_rst_n  in  1  asynchronous, active-low reset
init_end  in  1  init done; level, stays high after init
init_cmd/init_bank/init_addr  in  4/2/13  init sequencer bus
ar_req, ar_end  in  1,1  refresh request (level) / done pulse
ar_cmd/ar_bank/ar_addr  in  4/2/13  refresh bus
wr_req, wr_end  in  1,1  write request / done pulse
wr_cmd/wr_bank/wr_addr  in  4/2/13  write bus
wr_dq_oe, wr_data  in  1,16  write data drive enable / data
rd_req, rd_end  in  1,1  read request / done pulse
rd_cmd/rd_bank/rd_addr  in  4/2/13  read bus
ar_en, wr_en, rd_en  out  1 each  grants to sub-controllers
sdram_cke  out  1  clock enable
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
sdram_ba, sdram_addr  out  2,13  bank/address
sdram_dq_out, sdram_dq_oe  out  16,1  write data / tristate enable
err_timeout  out  1  sticky grant-timeout flag

Behaviour:
- Reset values:
  - state = INIT
  - cmd pins = CMD_NOP
  - ba = 2'b11, addr = 13'h1fff
  - dq_out = 0, dq_oe = 0, cke = 0
  - all *_en = 0, err_timeout = 0, last_grant = READ
- sdram_cke register is 0 in reset and 1 from the first clock after reset release.
- States: INIT, ARBIT, AREF, WRITE, READ. Registered state; next-state logic combinational.
- INIT:
  - Pin bus = init bus.
  - When init_end = 1, go to ARBIT next cycle.
- ARBIT:
  - Pin bus = NOP/11/1fff; dq_oe = 0.
  - If ar_req, go to AREF.
  - Else if wr_req && rd_req:
    - RR_WR_RD = 1: grant the opposite of last_grant.
    - RR_WR_RD = 0: grant WRITE.
  - Else if wr_req, go to WRITE.
  - Else if rd_req, go to READ.
  - Else stay in ARBIT.
  - last_grant updates on entry to WRITE or READ.
- AREF / WRITE / READ:
  - Pin bus = that requester's cmd/bank/addr, combinational pass-through with no added latency.
  - WRITE also drives dq_out = wr_data and dq_oe = wr_dq_oe. dq_oe = 0 in every other state.
  - Return to ARBIT the cycle after the matching *_end = 1. ar_req, wr_req and rd_req are ignored while in a grant state.
  - An ar_req arriving during WRITE/READ is serviced at the next ARBIT.
- Grant enables are combinational:
  - ar_en = (state==AREF) && !ar_end
  - wr_en = (state==WRITE) && !wr_end
  - rd_en = (state==READ) && !rd_end
  - The enable therefore drops in the same cycle as the done pulse, so the sub-controller cannot restart.
- Grant counter:
  - 16-bit; cleared in INIT and ARBIT; increments each cycle in a grant state.
  - If it reaches TIMEOUT_CYC-1 without the matching end: set err_timeout (sticky until reset), force ARBIT next cycle, drive NOP that cycle.
- Boundary cases:
  - *_end asserted in the wrong state is ignored.
  - A *_end in the same cycle the counter hits TIMEOUT_CYC-1 counts as a normal end; err_timeout stays 0.
  - init_end dropping after INIT is ignored.
  - Reset mid-grant: immediate return to reset values and INIT.
- Total one-cycle ARBIT bubble between consecutive grants.

Decomposition:
- Shared package/include:
  - Command encodings CMD_NOP/PRE/AR/ACT/WR/RD.
  - State localparams INIT/ARBIT/AREF/WRITE/READ.
  - Bus widths: 4 cmd, 2 bank, 13 addr, 16 data.
- Sub-module sdram_arbiter_grant:
  - Next-grant priority/round-robin selection from {ar_req, wr_req, rd_req, last_grant}.
  - Purely combinational; the rest of the FSM stays in the top.

Test Plan:
1. Reset then init_end = 1 at cycle 10 with init_cmd = 4'b0010 before it -> pins show 0010 during INIT; state ARBIT at cycle 11; pins NOP/11/1fff.
2. ar_req = 1 in ARBIT -> next cycle ar_en = 1 and pins = ar_cmd; ar_end pulse -> ar_en = 0 the same cycle, ARBIT the next cycle, no second refresh started.
3. wr_req and ar_req asserted together -> AREF granted first; WRITE granted after ar_end plus the one ARBIT cycle; dq_oe follows wr_dq_oe only in WRITE.
4. wr_req and rd_req held continuously, RR_WR_RD = 1 -> grants alternate WRITE, READ, WRITE; with RR_WR_RD = 0 -> WRITE every time.
5. Grant READ and never pulse rd_end, TIMEOUT_CYC = 20 -> at cycle 20 of the grant err_timeout = 1 and state returns to ARBIT; err_timeout remains 1.
6. Assert reset during WRITE -> all outputs return to reset values at once; INIT is re-entered; a new init_end is required to resume.
